regfile_param: RTL and testbench

Parametrised successor to the RISC-V processor register file. It has configurable data width and depth, two synchronous read ports with write-first bypass, and an optional hardwired-zero register 0. A built-in clear engine walks every word to zero after reset or on request. It sits in the decode stage of the pipeline and drives the operand registers directly.

---
 rtl/regfile_param.sv | 104 ++++++++++
 tb/tb_regfile_param.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_param.sv
// regfile_param: register file with configurable width and depth.
// It has registered write-first read ports, an optional zero register and a clear sweep.
// Ports: clk, rst_n (async, active-low), clear_req, busy,
//   rd_addr_a/b -> rd_data_a/b (1-cycle latency), wr_en/wr_addr/wr_data.
// Macro REGFILE_READ_C_EN adds a third read port, rd_addr_c -> rd_data_c.
module regfile_param #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter bit ZERO_REG   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear_req,
  output logic                  busy,
  input  logic [ADDR_WIDTH-1:0] rd_addr_a,
  input  logic [ADDR_WIDTH-1:0] rd_addr_b,
  output logic [DATA_WIDTH-1:0] rd_data_a,
  output logic [DATA_WIDTH-1:0] rd_data_b,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data
`ifdef REGFILE_READ_C_EN
  ,
  input  logic [ADDR_WIDTH-1:0] rd_addr_c,
  output logic [DATA_WIDTH-1:0] rd_data_c
`endif
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  wr_ok;

  // A write counts only when idle and not aimed at a hardwired zero.
  assign wr_ok = (state == IDLE) && wr_en &&
                 !(ZERO_REG && (wr_addr == '0));

  function automatic logic [DATA_WIDTH-1:0] rd_next(
    input logic [ADDR_WIDTH-1:0] a
  );
    logic [DATA_WIDTH-1:0] r;
    r = mem[a];
    if (state != IDLE)
      r = '0;
    else if (ZERO_REG && (a == '0))
      r = '0;
    else if (wr_ok && (a == wr_addr))
      r = wr_data;
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= CLEAR;
      cnt       <= '0;
      busy      <= 1'b1;
      rd_data_a <= '0;
      rd_data_b <= '0;
    end else begin
      rd_data_a <= rd_next(rd_addr_a);
      rd_data_b <= rd_next(rd_addr_b);
      unique case (state)
        CLEAR: begin
          cnt <= cnt + ADDR_WIDTH'(1);
          if (cnt == '1) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        IDLE: begin
          if (clear_req) begin
            state <= CLEAR;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
      endcase
    end
  end

  // Storage has no reset; the sweep zeroes it word by word.
  always_ff @(posedge clk) begin
    if (state == CLEAR)
      mem[cnt] <= '0;
    else if (wr_ok)
      mem[wr_addr] <= wr_data;
  end

`ifdef REGFILE_READ_C_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rd_data_c <= '0;
    else
      rd_data_c <= rd_next(rd_addr_c);
  end
`else
  // Two read ports only.
`endif

endmodule

// File: tb/tb_regfile_param.sv
// tb_regfile_param: directed bench with a behavioural model.
// Checks a zero-register and a plain-register instance side by side.
module tb_regfile_param;

  localparam int DEPTH = 32;

  logic        clk;
  logic        rst_n;
  logic        clear_req;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  rd_addr_a;
  logic [4:0]  rd_addr_b;
  logic        busy0, busy1;
  logic [31:0] a0, b0, a1, b1;
`ifdef REGFILE_READ_C_EN
  logic [4:0]  rd_addr_c;
  logic [31:0] c0, c1;
  logic        busy2;
  logic [15:0] a2, b2, c2;
  int          n2;
`endif

  int nvec = 0;
  int nerr = 0;
  bit chk_on = 0;

  regfile_param u0 (
    .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .busy(busy0),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(a0), .rd_data_b(b0),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
`ifdef REGFILE_READ_C_EN
    , .rd_addr_c(rd_addr_c), .rd_data_c(c0)
`endif
  );

  regfile_param #(.ZERO_REG(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .busy(busy1),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(a1), .rd_data_b(b1),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
`ifdef REGFILE_READ_C_EN
    , .rd_addr_c(rd_addr_c), .rd_data_c(c1)
`endif
  );

`ifdef REGFILE_READ_C_EN
  regfile_param #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) u2 (
    .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .busy(busy2),
    .rd_addr_a(rd_addr_a[2:0]), .rd_addr_b(rd_addr_b[2:0]),
    .rd_data_a(a2), .rd_data_b(b2),
    .wr_en(wr_en), .wr_addr(wr_addr[2:0]), .wr_data(wr_data[15:0]),
    .rd_addr_c(rd_addr_c[2:0]), .rd_data_c(c2)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m0 [DEPTH];
  logic [31:0] m1 [DEPTH];
  logic [31:0] ea0, eb0, ea1, eb1, ec0, ec1;
  logic        mbusy;
  int          left;

  function automatic logic [31:0] rdm(bit zr, logic [31:0] v,
                                      logic [4:0] a);
    if (zr && a == 5'd0) return 32'd0;
    if (wr_en && wr_addr == a) return wr_data;
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mbusy <= 1'b1;
      left  <= DEPTH;
      ea0 <= 0; eb0 <= 0; ea1 <= 0; eb1 <= 0; ec0 <= 0; ec1 <= 0;
    end else if (mbusy) begin
      m0[5'(DEPTH - left)] <= 32'd0;
      m1[5'(DEPTH - left)] <= 32'd0;
      left <= left - 1;
      if (left == 1) mbusy <= 1'b0;
      ea0 <= 0; eb0 <= 0; ea1 <= 0; eb1 <= 0; ec0 <= 0; ec1 <= 0;
    end else begin
      ea0 <= rdm(1'b1, m0[rd_addr_a], rd_addr_a);
      eb0 <= rdm(1'b1, m0[rd_addr_b], rd_addr_b);
      ea1 <= rdm(1'b0, m1[rd_addr_a], rd_addr_a);
      eb1 <= rdm(1'b0, m1[rd_addr_b], rd_addr_b);
`ifdef REGFILE_READ_C_EN
      ec0 <= rdm(1'b1, m0[rd_addr_c], rd_addr_c);
      ec1 <= rdm(1'b0, m1[rd_addr_c], rd_addr_c);
`endif
      if (wr_en) begin
        if (wr_addr != 5'd0) m0[wr_addr] <= wr_data;
        m1[wr_addr] <= wr_data;
      end
      if (clear_req) begin
        mbusy <= 1'b1;
        left  <= DEPTH;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("busy_zr", 32'(busy0), 32'(mbusy));
      check("busy_nz", 32'(busy1), 32'(mbusy));
      check("a_zr", a0, ea0);
      check("b_zr", b0, eb0);
      check("a_nz", a1, ea1);
      check("b_nz", b1, eb1);
`ifdef REGFILE_READ_C_EN
      check("c_zr", c0, ec0);
      check("c_nz", c1, ec1);
`endif
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic count_busy(string nm, int want);
    int n = 0;
    while (busy0 && n < 200) begin
`ifdef REGFILE_READ_C_EN
      if (busy2) n2++;
`endif
      tick();
      n++;
    end
    check(nm, 32'(n), 32'(want));
  endtask

  initial begin
    rst_n = 1'b0; clear_req = 1'b0; wr_en = 1'b0;
    wr_addr = '0; wr_data = '0; rd_addr_a = '0; rd_addr_b = '0;
`ifdef REGFILE_READ_C_EN
    rd_addr_c = '0; n2 = 0;
`endif
    repeat (3) @(posedge clk);
    chk_on = 1'b1;
    @(negedge clk);
    check("rst_busy", 32'(busy0), 32'd1);
    check("rst_a", a0, 32'd0);
    rst_n = 1'b1;
    count_busy("sweep_len", 32);
`ifdef REGFILE_READ_C_EN
    check("sweep_len_small", 32'(n2), 32'd8);
`endif

    for (int i = 0; i < DEPTH; i++) begin
      rd_addr_a = 5'(i);
      rd_addr_b = 5'(31 - i);
      tick();
      check("swept_a", a0, 32'd0);
      check("swept_b", b1, 32'd0);
    end

    // write then read, 1-cycle latency
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
    rd_addr_a = 5'd0;
    tick();
    wr_en = 1'b0; rd_addr_a = 5'd5;
    tick();
    check("lat_a", a0, 32'hDEADBEEF);

    // bypass on both ports
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h12345678;
    rd_addr_a = 5'd7; rd_addr_b = 5'd7;
    tick();
    check("byp_a", a0, 32'h12345678);
    check("byp_b", b0, 32'h12345678);
    wr_en = 1'b0;
    tick();
    check("byp_hold", a0, 32'h12345678);

    // zero register vs ordinary register 0
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
    rd_addr_a = 5'd0;
    tick();
    check("zr_byp", a0, 32'd0);
    check("nz_byp", a1, 32'hFFFFFFFF);
    wr_en = 1'b0;
    tick();
    check("zr_rd", a0, 32'd0);
    check("nz_rd", a1, 32'hFFFFFFFF);

    // mixed traffic, model-checked
    for (int i = 0; i < 24; i++) begin
      wr_en     = (i % 3) != 2;
      wr_addr   = 5'(i * 5 + 1);
      wr_data   = 32'((i + 1) * 32'h01010101);
      rd_addr_a = 5'((i - 1) * 5 + 1);
      rd_addr_b = wr_addr;
      tick();
      if (i == 0) check("mix_byp", b0, 32'h01010101);
    end
    wr_en = 1'b0;

`ifdef REGFILE_READ_C_EN
    wr_en = 1'b1; wr_addr = 5'd2; wr_data = 32'h0000BEEF;
    rd_addr_c = 5'd2;
    tick();
    check("c_byp_small", 32'(c2), 32'h0000BEEF);
    check("c_byp", c0, 32'h0000BEEF);
    wr_en = 1'b0;
`endif

    // clear on request; write in the request cycle and during busy
    wr_en = 1'b1; wr_addr = 5'd31; wr_data = 32'hA5A5A5A5;
    tick();
    clear_req = 1'b1; wr_addr = 5'd4; wr_data = 32'h44;
    rd_addr_a = 5'd31;
    tick();
    clear_req = 1'b0;
    check("clr_busy", 32'(busy0), 32'd1);
    wr_addr = 5'd3; wr_data = 32'h33;
    count_busy("clr_len", 32);
    wr_en = 1'b0;
    rd_addr_a = 5'd31; rd_addr_b = 5'd3;
    tick();
    check("clr_31", a0, 32'd0);
    check("clr_3", b0, 32'd0);
    rd_addr_a = 5'd4;
    tick();
    check("clr_4", a1, 32'd0);

    // reset in the middle of a sweep
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h99;
    tick();
    wr_en = 1'b0; rd_addr_a = 5'd9;
    tick();
    check("pre_rst", a0, 32'h99);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    repeat (10) tick();
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", 32'(busy0), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    count_busy("restart_len", 32);
    tick();
    check("post_rst", a0, 32'd0);

    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
